// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: PC generation, I-cache lookup with a memory fallback
// on miss, and a DEPTH-entry {pc, instr, redir} queue feeding decode.
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_if_pce,
  input  logic [XLEN-1:0] ex_if_pc,
  output logic [XLEN-1:0] ic_addr,
  input  logic            ic_hit,
  input  logic [XLEN-1:0] ic_data,
  output logic            ic_fill_en,
  output logic [XLEN-1:0] ic_fill_addr,
  output logic [XLEN-1:0] ic_fill_data,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ok,
  input  logic [XLEN-1:0] mem_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_is,
  output logic            id_redir
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pcNext;
  logic [XLEN-1:0] npc_q;
  logic [XLEN-1:0] memAddr_q;
  logic            redirFlag_q;
  logic            fillEn_q;
  logic [XLEN-1:0] fillAddr_q, fillData_q;

  logic [XLEN-1:0] pcMem_q    [DEPTH];
  logic [XLEN-1:0] isMem_q    [DEPTH];
  logic            redirMem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic [CW-1:0]   count_q;

  logic deq, full, hitEnq, missIssue, missEnq, enq;
  logic [XLEN-1:0] enqPc, enqIs;

  // A flush beats decode's accept, and a slot freed by this cycle's dequeue is usable.
  assign deq       = (count_q != '0) && id_ready && !ex_if_pce;
  assign full      = (count_q == CW'(DEPTH)) && !deq;
  assign hitEnq    = (state_q == IDLE) && !ex_if_pce && !full && ic_hit;
  assign missIssue = (state_q == IDLE) && !ex_if_pce && !full && !ic_hit;
  assign missEnq   = (state_q == WAIT) && mem_ok && !ex_if_pce;
  assign enq       = hitEnq || missEnq;
  assign enqPc     = hitEnq ? pc_q : memAddr_q;
  assign enqIs     = hitEnq ? ic_data : mem_data;
  assign pcNext    = pc_q + XLEN'(PC_STEP);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (missIssue) state_d = WAIT;
      WAIT:    if (mem_ok) state_d = IDLE; else if (ex_if_pce) state_d = DROP;
      DROP:    if (mem_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    if (state_q == WAIT) mem_req = 1'b1;
  end

  // The newest redirect target always wins, including one arriving with the drop response.
  always_comb begin
    pc_d = pc_q;
    case (state_q)
      IDLE:    if (ex_if_pce) pc_d = ex_if_pc; else if (hitEnq) pc_d = pcNext;
      WAIT:    if (mem_ok) pc_d = ex_if_pce ? ex_if_pc : pcNext;
      DROP:    if (mem_ok) pc_d = ex_if_pce ? ex_if_pc : npc_q;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      npc_q       <= '0;
      memAddr_q   <= '0;
      redirFlag_q <= 1'b1;
      fillEn_q    <= 1'b0;
      fillAddr_q  <= '0;
      fillData_q  <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcMem_q[i]    <= '0;
        isMem_q[i]    <= '0;
        redirMem_q[i] <= 1'b0;
      end
    end else begin
      pc_q     <= pc_d;
      fillEn_q <= missEnq;
      if (missIssue) memAddr_q <= pc_q;
      if (ex_if_pce && (state_q != IDLE)) npc_q <= ex_if_pc;
      if (missEnq) begin
        fillAddr_q <= memAddr_q;
        fillData_q <= mem_data;
      end
      if (ex_if_pce)  redirFlag_q <= 1'b1;
      else if (enq)   redirFlag_q <= 1'b0;
      if (ex_if_pce) begin
        rdPtr_q <= wrPtr_q;
        count_q <= '0;
      end else begin
        if (enq) begin
          pcMem_q[wrPtr_q]    <= enqPc;
          isMem_q[wrPtr_q]    <= enqIs;
          redirMem_q[wrPtr_q] <= redirFlag_q;
          wrPtr_q             <= wrPtr_q + 1'b1;
        end
        if (deq) rdPtr_q <= rdPtr_q + 1'b1;
        count_q <= count_q + CW'(enq) - CW'(deq);
      end
    end
  end

  assign ic_addr      = pc_q;
  assign mem_addr     = memAddr_q;
  assign ic_fill_en   = fillEn_q;
  assign ic_fill_addr = fillAddr_q;
  assign ic_fill_data = fillData_q;
  assign id_valid     = (count_q != '0);
  assign id_pc        = pcMem_q[rdPtr_q];
  assign id_is        = isMem_q[rdPtr_q];
  assign id_redir     = redirMem_q[rdPtr_q];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus a randomized phase, all
// checked each cycle against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        ex_if_pce;
  logic [31:0] ex_if_pc;
  logic [31:0] ic_addr;
  logic        ic_hit;
  logic [31:0] ic_data;
  logic        ic_fill_en;
  logic [31:0] ic_fill_addr;
  logic [31:0] ic_fill_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ok;
  logic [31:0] mem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_is;
  logic        id_redir;

  fetch_queue_unit #(
    .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_if_pce(ex_if_pce), .ex_if_pc(ex_if_pc),
    .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_data(ic_data),
    .ic_fill_en(ic_fill_en), .ic_fill_addr(ic_fill_addr), .ic_fill_data(ic_fill_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ok(mem_ok), .mem_data(mem_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_is(id_is),
    .id_redir(id_redir)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] is;
    logic        redir;
  } entry_t;

  // Reference model: the decode-visible queue plus the fetch PC and miss bookkeeping.
  entry_t      mQ[$];
  logic [31:0] mPc, mReqAddr, mTarget, mFillAddr, mFillData;
  bit          mFlag, mMissing, mDropping, mFillEn;
  bit          checking = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic pce, input logic [31:0] tgt,
                               input logic hit, input logic ok, input logic rdy);
    rst       = r;
    ex_if_pce = pce;
    ex_if_pc  = tgt;
    ic_hit    = hit;
    ic_data   = $urandom;
    mem_ok    = ok;
    mem_data  = $urandom;
    id_ready  = rdy;
  endtask

  task automatic compareModel();
    checkOutput("ic_addr", ic_addr, mPc);
    checkOutput("mem_req", 32'(mem_req), 32'(mMissing));
    if (mMissing) checkOutput("mem_addr", mem_addr, mReqAddr);
    checkOutput("fill_en", 32'(ic_fill_en), 32'(mFillEn));
    if (mFillEn) begin
      checkOutput("fill_addr", ic_fill_addr, mFillAddr);
      checkOutput("fill_data", ic_fill_data, mFillData);
    end
    checkOutput("id_valid", 32'(id_valid), 32'(mQ.size() != 0));
    if (mQ.size() != 0) begin
      checkOutput("id_pc", id_pc, mQ[0].pc);
      checkOutput("id_is", id_is, mQ[0].is);
      checkOutput("id_redir", 32'(id_redir), 32'(mQ[0].redir));
    end
  endtask

  task automatic modelStep();
    bit deq, fullNow;
    entry_t e;
    if (!rst) begin
      mQ.delete();
      mPc = 32'h0; mReqAddr = 32'h0; mTarget = 32'h0;
      mFlag = 1; mMissing = 0; mDropping = 0; mFillEn = 0;
    end else begin
      deq     = (mQ.size() != 0) && id_ready && !ex_if_pce;
      fullNow = (mQ.size() == DEPTH) && !deq;
      mFillEn = 0;
      if (ex_if_pce) begin
        mQ.delete();
        mFlag = 1;
        if (mMissing) begin
          mMissing = 0;
          if (mem_ok) mPc = ex_if_pc;
          else begin mDropping = 1; mTarget = ex_if_pc; end
        end else if (mDropping) begin
          if (mem_ok) begin mDropping = 0; mPc = ex_if_pc; end
          else mTarget = ex_if_pc;
        end else begin
          mPc = ex_if_pc;
        end
      end else begin
        if (deq) void'(mQ.pop_front());
        if (mMissing) begin
          if (mem_ok) begin
            e.pc = mReqAddr; e.is = mem_data; e.redir = mFlag;
            mQ.push_back(e);
            mFlag = 0; mFillEn = 1; mFillAddr = mReqAddr; mFillData = mem_data;
            mPc = mPc + 32'd4; mMissing = 0;
          end
        end else if (mDropping) begin
          if (mem_ok) begin mDropping = 0; mPc = mTarget; end
        end else if (!fullNow) begin
          if (ic_hit) begin
            e.pc = mPc; e.is = ic_data; e.redir = mFlag;
            mQ.push_back(e);
            mFlag = 0; mPc = mPc + 32'd4;
          end else begin
            mMissing = 1; mReqAddr = mPc;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (checking) compareModel();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] tgt;
    logic [31:0] hitData;

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checking = 1;
    tick();
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_fill_en", 32'(ic_fill_en), 32'h0);
    checkOutput("rst_id_valid", 32'(id_valid), 32'h0);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_id_is", id_is, 32'h0);
    checkOutput("rst_id_redir", 32'(id_redir), 32'h0);
    checkOutput("rst_ic_addr", ic_addr, 32'h0);

    // Hit stream
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 1);
      hitData = ic_data;
      tick();
      checkOutput("hit_pc", id_pc, 32'(4 * i));
      checkOutput("hit_is", id_is, hitData);
      checkOutput("hit_redir", 32'(id_redir), 32'(i == 0));
      checkOutput("hit_mem_req", 32'(mem_req), 32'h0);
    end

    // Backpressure: fill to DEPTH, then drain in order
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 0);
      tick();
    end
    checkOutput("bp_ic_addr", ic_addr, 32'h10);
    checkOutput("bp_head_pc", id_pc, 32'h0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 1);
      tick();
      checkOutput("drain_pc", id_pc, 32'(4 * (i + 1)));
    end

    // Miss at 0x20 answered after three cycles
    applyStimulus(1, 1, 32'h20, 1, 0, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("miss_req", 32'(mem_req), 32'h1);
      checkOutput("miss_addr", mem_addr, 32'h20);
      applyStimulus(1, 0, 0, 0, i == 2, 1);
      if (i == 2) mem_data = 32'h00500093;
      tick();
    end
    checkOutput("miss_fill_en", 32'(ic_fill_en), 32'h1);
    checkOutput("miss_fill_addr", ic_fill_addr, 32'h20);
    checkOutput("miss_fill_data", ic_fill_data, 32'h00500093);
    checkOutput("miss_id_pc", id_pc, 32'h20);
    checkOutput("miss_id_is", id_is, 32'h00500093);
    checkOutput("miss_id_redir", 32'(id_redir), 32'h1);
    checkOutput("miss_req_done", 32'(mem_req), 32'h0);
    applyStimulus(1, 0, 0, 1, 0, 1);
    tick();
    checkOutput("miss_fill_once", 32'(ic_fill_en), 32'h0);

    // Redirect while waiting on memory
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(1, 1, 32'h100, 0, 0, 1);
    tick();
    checkOutput("drop_req", 32'(mem_req), 32'h0);
    checkOutput("drop_flush", 32'(id_valid), 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 1, 1);
    tick();
    checkOutput("drop_no_fill", 32'(ic_fill_en), 32'h0);
    checkOutput("drop_ic_addr", ic_addr, 32'h100);
    checkOutput("drop_no_enq", 32'(id_valid), 32'h0);
    applyStimulus(1, 0, 0, 1, 0, 1);
    tick();
    checkOutput("drop_first_pc", id_pc, 32'h100);
    checkOutput("drop_first_redir", 32'(id_redir), 32'h1);

    // Redirect coinciding with mem_ok
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick();
    tick();
    applyStimulus(1, 1, 32'h200, 0, 1, 1);
    tick();
    checkOutput("coin_no_fill", 32'(ic_fill_en), 32'h0);
    checkOutput("coin_no_enq", 32'(id_valid), 32'h0);
    checkOutput("coin_ic_addr", ic_addr, 32'h200);
    checkOutput("coin_req", 32'(mem_req), 32'h0);
    applyStimulus(1, 0, 0, 1, 0, 1);
    tick();
    checkOutput("coin_next_pc", id_pc, 32'h200);

    // Reset mid-miss, then a late mem_ok
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("rmiss_req", 32'(mem_req), 32'h0);
    checkOutput("rmiss_valid", 32'(id_valid), 32'h0);
    checkOutput("rmiss_ic_addr", ic_addr, 32'h0);
    applyStimulus(1, 0, 0, 1, 1, 1);
    tick();
    checkOutput("late_ok_fill", 32'(ic_fill_en), 32'h0);
    checkOutput("late_ok_pc", id_pc, 32'h0);

    // PC wrap
    applyStimulus(1, 1, 32'hFFFF_FFFC, 1, 0, 1);
    tick();
    applyStimulus(1, 0, 0, 1, 0, 1);
    tick();
    checkOutput("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_ic_addr", ic_addr, 32'h0);

    // Randomized phase
    for (int n = 0; n < 2000; n++) begin
      tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 11) == 0, tgt,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1);
      tick();
    end
    @(negedge clk);
    compareModel();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
